z16_fetch_unit: RTL and testbench

Instruction-fetch sequencer for the Z16 core. Owns the single combinational read port of the Z16 instruction memory and arbitrates it between sequential PC fetch and a debug read port. Fetched words go into a small prefetch FIFO, which delivers them to decode over a valid/ready handshake. Branch redirects flush the FIFO and restart fetch.

---
 rtl/z16_fetch_unit.sv | 200 ++++++++++++++++++++
 tb/tb_z16_fetch_unit.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z16_fetch_unit.sv
// -----------------------------------------------------------------------------
// z16_fetch_unit
//
// Instruction-fetch sequencer for the Z16 core. Owns the single combinational
// read port of the instruction memory and shares it between sequential PC
// fetch and a debug read port. Fetched words land in a small prefetch FIFO
// that feeds decode over a valid/ready handshake. A branch redirect flushes
// the FIFO and restarts fetch at the target.
//
// Parameters
//   RESET_PC  fetch address after reset (bit 0 ignored)
//   DEPTH     prefetch FIFO entries, power of two in 2..8
//
// Optional feature
//   Z16_FETCH_HALT_EN  when defined, a fetched 16'h0000 word is delivered and
//                      then stops fetch (o_halted = 1) until the next redirect.
//                      When undefined, 16'h0000 is an ordinary instruction and
//                      o_halted is tied to 0.
//
// Ports
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   o_imem_addr, i_imem_instr instruction memory port (read data same cycle)
//   o_instr, o_instr_pc       FIFO head word and its PC
//   o_instr_valid             FIFO non-empty
//   i_instr_ready             decode accepts the head this cycle
//   i_redirect, i_redirect_pc flush and restart fetch at the target
//   i_dbg_req, i_dbg_addr     debug read request (held until granted)
//   o_dbg_gnt                 debug owns the memory port this cycle
//   o_dbg_data, o_dbg_valid   registered debug read data, valid one cycle
//   o_halted                  fetch stopped by a halt word
// -----------------------------------------------------------------------------
module z16_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [15:0] o_imem_addr,
  input  logic [15:0] i_imem_instr,
  output logic [15:0] o_instr,
  output logic [15:0] o_instr_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  input  logic        i_dbg_req,
  input  logic [15:0] i_dbg_addr,
  output logic        o_dbg_gnt,
  output logic [15:0] o_dbg_data,
  output logic        o_dbg_valid,
  output logic        o_halted
);

  // Pointer and occupancy widths. DEPTH is a power of two, so the pointers
  // wrap naturally and the count needs one extra bit to represent "full".
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [15:0]   PC_RESET = {RESET_PC[15:1], 1'b0};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q,    count_d;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic          dbg_last_q, dbg_last_d;
  logic          halted_q,   halted_d;
  logic          dbg_valid_q, dbg_valid_d;
  logic [15:0]   dbg_data_q,  dbg_data_d;

  // Each FIFO entry holds {pc, instr}.
  logic [31:0]   fifo_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Request / arbitration
  // ---------------------------------------------------------------------------
  logic pop;
  logic want_fetch;
  logic dbg_gnt;
  logic push;

  // Bit 0 of both byte addresses is discarded; the names keep that explicit.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = i_redirect_pc[0] ^ i_dbg_addr[0];

  assign pop        = (count_q != '0) && i_instr_ready;
  // A slot is available if the FIFO is not full, or if the head leaves this
  // same cycle. Redirect and halt suppress fetch entirely.
  assign want_fetch = !i_redirect && !halted_q && ((count_q < DEPTH_C) || pop);
  // Debug normally wins, except right after a debug grant when fetch also
  // wants the port: this alternates ownership under contention.
  assign dbg_gnt    = i_dbg_req && !(dbg_last_q && want_fetch);
  assign push       = want_fetch && !dbg_gnt;

  assign o_imem_addr = dbg_gnt ? {i_dbg_addr[15:1], 1'b0} : fetch_pc_q;
  assign o_dbg_gnt   = dbg_gnt;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    fetch_pc_d  = fetch_pc_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    halted_d    = halted_q;
    dbg_last_d  = dbg_gnt;
    dbg_valid_d = dbg_gnt;
    dbg_data_d  = dbg_gnt ? i_imem_instr : dbg_data_q;

    if (i_redirect) begin
      // Redirect overrides any push or pop this cycle.
      fetch_pc_d = {i_redirect_pc[15:1], 1'b0};
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      halted_d   = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PTR_ONE;
        fetch_pc_d = fetch_pc_q + 16'd2;   // 16-bit, wraps FFFE -> 0000
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_d = count_q - CNT_ONE;
      end
`ifdef Z16_FETCH_HALT_EN
      // The halt word itself is still pushed; only later fetches stop.
      if (push && (i_imem_instr == 16'h0000)) begin
        halted_d = 1'b1;
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc_q  <= PC_RESET;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      dbg_last_q  <= 1'b0;
      halted_q    <= 1'b0;
      dbg_valid_q <= 1'b0;
      dbg_data_q  <= 16'h0000;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      dbg_last_q  <= dbg_last_d;
      halted_q    <= halted_d;
      dbg_valid_q <= dbg_valid_d;
      dbg_data_q  <= dbg_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; entries are only observable once
  // count says they hold a pushed word, so clearing them buys nothing.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {fetch_pc_q, i_imem_instr};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decode-side outputs come straight from registers.
  // ---------------------------------------------------------------------------
  assign o_instr_valid = (count_q != '0);
  assign o_instr_pc    = fifo_mem[rd_ptr_q][31:16];
  assign o_instr       = fifo_mem[rd_ptr_q][15:0];
  assign o_dbg_data    = dbg_data_q;
  assign o_dbg_valid   = dbg_valid_q;

`ifdef Z16_FETCH_HALT_EN
  assign o_halted = halted_q;
`else
  assign o_halted = 1'b0;
`endif

endmodule

// File: tb/tb_z16_fetch_unit.sv
// -----------------------------------------------------------------------------
// Testbench for z16_fetch_unit: directed scenarios plus a randomized run, all
// checked against a queue-based behavioural model of the fetch unit.
// -----------------------------------------------------------------------------
module tb_z16_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          DEPTH    = 2;
`ifdef Z16_FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [15:0] o_imem_addr;
  logic [15:0] i_imem_instr;
  logic [15:0] o_instr;
  logic [15:0] o_instr_pc;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic        i_redirect;
  logic [15:0] i_redirect_pc;
  logic        i_dbg_req;
  logic [15:0] i_dbg_addr;
  logic        o_dbg_gnt;
  logic [15:0] o_dbg_data;
  logic        o_dbg_valid;
  logic        o_halted;

  always #5 i_clk = ~i_clk;

  // Instruction memory, word-indexed, read combinationally.
  logic [15:0] mem [0:32767];
  assign i_imem_instr = mem[o_imem_addr[15:1]];

  z16_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .o_imem_addr   (o_imem_addr),
    .i_imem_instr  (i_imem_instr),
    .o_instr       (o_instr),
    .o_instr_pc    (o_instr_pc),
    .o_instr_valid (o_instr_valid),
    .i_instr_ready (i_instr_ready),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_dbg_req     (i_dbg_req),
    .i_dbg_addr    (i_dbg_addr),
    .o_dbg_gnt     (o_dbg_gnt),
    .o_dbg_data    (o_dbg_data),
    .o_dbg_valid   (o_dbg_valid),
    .o_halted      (o_halted)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------------------------------------------------------------------
  // Behavioural model: the prefetch buffer is a queue of {pc, word} pairs.
  // ---------------------------------------------------------------------------
  logic [15:0] q_pc[$];
  logic [15:0] q_ins[$];
  logic [15:0] m_pc;
  bit          m_dbg_last, m_halted, m_dbg_valid;
  logic [15:0] m_dbg_data;

  // Expected values for the current cycle.
  bit          e_valid, e_gnt, e_pop, e_fetch;
  logic [15:0] e_addr, e_instr, e_ipc;

  function automatic void model_reset();
    q_pc.delete();
    q_ins.delete();
    m_pc        = {RESET_PC[15:1], 1'b0};
    m_dbg_last  = 1'b0;
    m_halted    = 1'b0;
    m_dbg_valid = 1'b0;
    m_dbg_data  = 16'h0000;
  endfunction

  function automatic void model_eval();
    bit room;
    e_valid = (q_pc.size() != 0);
    e_instr = e_valid ? q_ins[0] : 16'h0000;
    e_ipc   = e_valid ? q_pc[0]  : 16'h0000;
    e_pop   = e_valid && i_instr_ready;
    room    = !i_redirect && !m_halted && ((q_pc.size() < DEPTH) || e_pop);
    e_gnt   = i_dbg_req && !(m_dbg_last && room);
    e_fetch = room && !e_gnt;
    e_addr  = e_gnt ? {i_dbg_addr[15:1], 1'b0} : m_pc;
  endfunction

  function automatic void model_update();
    logic [15:0] w;
    w = mem[e_addr[15:1]];
    if (i_redirect) begin
      q_pc.delete();
      q_ins.delete();
      m_pc     = {i_redirect_pc[15:1], 1'b0};
      m_halted = 1'b0;
    end else begin
      if (e_pop) begin
        void'(q_pc.pop_front());
        void'(q_ins.pop_front());
      end
      if (e_fetch) begin
        q_pc.push_back(m_pc);
        q_ins.push_back(w);
        m_pc = m_pc + 16'd2;
        if (HALT_EN && w == 16'h0000) m_halted = 1'b1;
      end
    end
    m_dbg_valid = e_gnt;
    if (e_gnt) m_dbg_data = w;
    m_dbg_last = e_gnt;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no checking inside)
  // ---------------------------------------------------------------------------
  task automatic drive(input bit rdy, input bit redir, input logic [15:0] rpc,
                       input bit req, input logic [15:0] daddr);
    i_instr_ready = rdy;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    i_dbg_req     = req;
    i_dbg_addr    = daddr;
  endtask

  // Inputs change at posedge+1; outputs are sampled at the falling edge.
  task automatic sample();
    @(negedge i_clk);
    model_eval();
  endtask

  task automatic advance();
    model_update();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    i_rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    // Values while reset is held, with a debug request pending.
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0025);
    #3;
    n_cmp++; if (o_instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", o_instr_valid); end
    n_cmp++; if (o_halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted: got %b want 0", o_halted); end
    n_cmp++; if (o_dbg_valid !== 1'b0 || o_dbg_data !== 16'h0000) begin n_bad++; $display("FAIL rst_dbg: got %b/%h want 0/0000", o_dbg_valid, o_dbg_data); end
    n_cmp++; if (o_dbg_gnt !== 1'b1 || o_imem_addr !== 16'h0024) begin n_bad++; $display("FAIL rst_dbg_port: got %b/%h want 1/0024", o_dbg_gnt, o_imem_addr); end
    i_dbg_req = 1'b0;
    #1;
    n_cmp++; if (o_dbg_gnt !== 1'b0 || o_imem_addr !== RESET_PC) begin n_bad++; $display("FAIL rst_fetch_port: got %b/%h want 0/%h", o_dbg_gnt, o_imem_addr, RESET_PC); end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    model_reset();

    // A debug response in flight is dropped by an asynchronous reset.
    drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0012);
    sample();
    advance();
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
    n_cmp++; if (o_dbg_valid !== 1'b1 || o_dbg_data !== 16'hB00B) begin n_bad++; $display("FAIL rst_pre_dbg: got %b/%h want 1/B00B", o_dbg_valid, o_dbg_data); end
    i_rst_n = 1'b0;
    #1;
    n_cmp++; if (o_dbg_valid !== 1'b0 || o_dbg_data !== 16'h0000) begin n_bad++; $display("FAIL rst_async_dbg: got %b/%h want 0/0000", o_dbg_valid, o_dbg_data); end
    do_reset();
  endtask

  task automatic test_stream();
    logic [15:0] x_pc  [4] = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
    logic [15:0] x_ins [4] = '{16'h0040, 16'h0050, 16'h0080, 16'h7849};
    do_reset();
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
    sample();
    n_cmp++; if (o_instr_valid !== 1'b0 || o_imem_addr !== 16'h0000) begin n_bad++; $display("FAIL stream_c0: got %b/%h want 0/0000", o_instr_valid, o_imem_addr); end
    advance();
    for (int i = 0; i < 4; i++) begin
      sample();
      n_cmp++;
      if (o_instr_valid !== 1'b1 || o_instr_pc !== x_pc[i] || o_instr !== x_ins[i]) begin
        n_bad++; $display("FAIL stream_head%0d: got %b %h@%h want 1 %h@%h", i, o_instr_valid, o_instr, o_instr_pc, x_ins[i], x_pc[i]);
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    for (int c = 0; c < 5; c++) begin
      sample();
      if (c >= 2) begin
        n_cmp++;
        if (o_imem_addr !== 16'h0004 || o_instr_valid !== 1'b1 || o_instr_pc !== 16'h0000) begin
          n_bad++; $display("FAIL bp_stall%0d: got addr %h valid %b pc %h want 0004 1 0000", c, o_imem_addr, o_instr_valid, o_instr_pc);
        end
      end
      advance();
    end
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      logic [15:0] wpc;
      wpc = 16'(2 * i);
      sample();
      n_cmp++;
      if (o_instr_valid !== 1'b1 || o_instr_pc !== wpc || o_instr !== mem[i]) begin
        n_bad++; $display("FAIL bp_drain%0d: got %b %h@%h want 1 %h@%h", i, o_instr_valid, o_instr, o_instr_pc, mem[i], wpc);
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    repeat (3) begin sample(); advance(); end
    // FIFO full; pop the head and redirect in the same cycle.
    drive(1'b1, 1'b1, 16'h0013, 1'b0, 16'h0000);
    sample();
    n_cmp++; if (o_instr_valid !== 1'b1 || o_instr_pc !== 16'h0000) begin n_bad++; $display("FAIL redir_pre: got %b@%h want 1@0000", o_instr_valid, o_instr_pc); end
    advance();
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
    sample();
    n_cmp++; if (o_instr_valid !== 1'b0 || o_imem_addr !== 16'h0012) begin n_bad++; $display("FAIL redir_next: got %b/%h want 0/0012", o_instr_valid, o_imem_addr); end
    advance();
    sample();
    n_cmp++; if (o_instr_valid !== 1'b1 || o_instr_pc !== 16'h0012 || o_instr !== 16'hB00B) begin n_bad++; $display("FAIL redir_tgt: got %b %h@%h want 1 B00B@0012", o_instr_valid, o_instr, o_instr_pc); end
    advance();
    sample();
    n_cmp++; if (o_instr_pc !== 16'h0014) begin n_bad++; $display("FAIL redir_seq: got pc %h want 0014", o_instr_pc); end
    advance();
  endtask

  task automatic test_contention();
    do_reset();
    drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0012);
    for (int c = 0; c < 8; c++) begin
      bit          x_gnt;
      logic [15:0] x_addr;
      sample();
      x_gnt  = (c % 2 == 0);
      x_addr = x_gnt ? 16'h0012 : 16'(c - 1);
      n_cmp++; if (o_dbg_gnt !== x_gnt || o_imem_addr !== x_addr) begin n_bad++; $display("FAIL cont_gnt%0d: got %b/%h want %b/%h", c, o_dbg_gnt, o_imem_addr, x_gnt, x_addr); end
      if (c > 0) begin
        n_cmp++;
        if (o_dbg_valid !== !x_gnt || (!x_gnt && o_dbg_data !== 16'hB00B)) begin
          n_bad++; $display("FAIL cont_dbg%0d: got %b/%h want %b/B00B", c, o_dbg_valid, o_dbg_data, !x_gnt);
        end
      end
      if (c >= 2 && x_gnt) begin
        n_cmp++;
        if (o_instr_valid !== 1'b1 || o_instr_pc !== 16'(c - 2)) begin
          n_bad++; $display("FAIL cont_head%0d: got %b@%h want 1@%h", c, o_instr_valid, o_instr_pc, 16'(c - 2));
        end
      end
      advance();
    end
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b1, 1'b1, 16'hFFFE, 1'b0, 16'h0000);
    sample(); advance();
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
    sample();
    n_cmp++; if (o_imem_addr !== 16'hFFFE) begin n_bad++; $display("FAIL wrap_addr: got %h want FFFE", o_imem_addr); end
    advance();
    sample();
    n_cmp++; if (o_instr_valid !== 1'b1 || o_instr_pc !== 16'hFFFE || o_instr !== mem[32767]) begin n_bad++; $display("FAIL wrap_top: got %b %h@%h want 1 %h@FFFE", o_instr_valid, o_instr, o_instr_pc, mem[32767]); end
    advance();
    sample();
    n_cmp++; if (o_instr_valid !== 1'b1 || o_instr_pc !== 16'h0000 || o_instr !== mem[0]) begin n_bad++; $display("FAIL wrap_zero: got %b %h@%h want 1 %h@0000", o_instr_valid, o_instr, o_instr_pc, mem[0]); end
    advance();
  endtask

  task automatic test_halt();
    do_reset();
    drive(1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000);
    sample(); advance();
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
    for (int k = 1; k <= 6; k++) begin
      sample();
      if (k == 4) begin
        n_cmp++; if (o_instr_valid !== 1'b1 || o_instr_pc !== 16'h0014 || o_instr !== 16'h0000) begin n_bad++; $display("FAIL halt_word: got %b %h@%h want 1 0000@0014", o_instr_valid, o_instr, o_instr_pc); end
      end
      if (k >= 4) begin
        n_cmp++; if (o_halted !== HALT_EN) begin n_bad++; $display("FAIL halt_flag%0d: got %b want %b", k, o_halted, HALT_EN); end
      end
      if (k == 5) begin
        n_cmp++;
        if (HALT_EN ? (o_instr_valid !== 1'b0) : (o_instr_valid !== 1'b1 || o_instr_pc !== 16'h0016)) begin
          n_bad++; $display("FAIL halt_after: got %b@%h want %b@0016", o_instr_valid, o_instr_pc, !HALT_EN);
        end
      end
      advance();
    end
    // A debug read still works while halted.
    drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0012);
    sample(); advance();
    drive(1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000);
    n_cmp++; if (o_dbg_valid !== 1'b1 || o_dbg_data !== 16'hB00B) begin n_bad++; $display("FAIL halt_dbg: got %b/%h want 1/B00B", o_dbg_valid, o_dbg_data); end
    sample(); advance();
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
    sample();
    n_cmp++; if (o_halted !== 1'b0 || o_imem_addr !== 16'h0000) begin n_bad++; $display("FAIL halt_resume: got %b/%h want 0/0000", o_halted, o_imem_addr); end
    advance();
    sample();
    n_cmp++; if (o_instr_valid !== 1'b1 || o_instr_pc !== 16'h0000) begin n_bad++; $display("FAIL halt_resume_head: got %b@%h want 1@0000", o_instr_valid, o_instr_pc); end
    advance();
  endtask

  task automatic test_random();
    bit          req;
    logic [15:0] daddr;
    do_reset();
    req   = 1'b0;
    daddr = 16'h0000;
    for (int c = 0; c < 600; c++) begin
      bit          redir;
      logic [15:0] rpc;
      if (c == 300) do_reset();
      redir = ($urandom_range(0, 99) < 4);
      rpc   = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 63));
      drive(($urandom_range(0, 3) != 0), redir, rpc, req, daddr);
      sample();
      n_cmp++; if (o_instr_valid !== e_valid) begin n_bad++; $display("FAIL rnd_valid c%0d: got %b want %b", c, o_instr_valid, e_valid); end
      if (e_valid) begin
        n_cmp++; if (o_instr !== e_instr || o_instr_pc !== e_ipc) begin n_bad++; $display("FAIL rnd_head c%0d: got %h@%h want %h@%h", c, o_instr, o_instr_pc, e_instr, e_ipc); end
      end
      n_cmp++; if (o_dbg_gnt !== e_gnt || o_imem_addr !== e_addr) begin n_bad++; $display("FAIL rnd_port c%0d: got %b/%h want %b/%h", c, o_dbg_gnt, o_imem_addr, e_gnt, e_addr); end
      n_cmp++; if (o_dbg_valid !== m_dbg_valid || o_dbg_data !== m_dbg_data) begin n_bad++; $display("FAIL rnd_dbg c%0d: got %b/%h want %b/%h", c, o_dbg_valid, o_dbg_data, m_dbg_valid, m_dbg_data); end
      n_cmp++; if (o_halted !== (HALT_EN && m_halted)) begin n_bad++; $display("FAIL rnd_halt c%0d: got %b want %b", c, o_halted, m_halted); end
      // Requester: hold until granted, then drop or start a fresh read.
      if (!req || e_gnt) begin
        req   = ($urandom_range(0, 3) == 0);
        daddr = 16'($urandom);
      end
      advance();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    i_rst_n = 1'b0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom_range(1, 65535));
    mem[0]  = 16'h0040;
    mem[1]  = 16'h0050;
    mem[2]  = 16'h0080;
    mem[3]  = 16'h7849;
    mem[9]  = 16'hB00B;
    mem[10] = 16'h0000;
    model_reset();

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_contention();
    test_wrap();
    test_halt();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
